bsg_link_oddr_upstream_sender: RTL and testbench



---
 rtl/bsg_link_pkg.sv | 20 ++
 rtl/bsg_two_fifo.sv | 46 ++++
 rtl/bsg_link_oddr_upstream_sender.sv | 115 +++++++++++
 tb/tb_bsg_link_oddr_upstream_sender.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bsg_link_pkg.sv
// Shared definitions for the ODDR link upstream sender.
//   link_state_e  : sender FSM states (RESET -> SYNC -> RUN)
//   credit_width  : width of a credit counter that must hold 2^lg_depth
//   idle_word_lp  : value driven to the PHY when no word is being sent
package bsg_link_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        SYNC  = 2'd1,
        RUN   = 2'd2
    } link_state_e;

    // One extra bit so the full-buffer count 2^lg_depth is representable.
    function automatic int credit_width(input int lg_depth);
        return lg_depth + 1;
    endfunction

    localparam int idle_word_lp = 0;

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO with valid/ready on the input and valid/yumi on the output.
//   clk_i, reset_i : clock, synchronous active-high clear
//   ready_o        : not full; caller only raises v_i when ready_o is 1
//   v_i, data_i    : enqueue
//   v_o, data_o    : head entry
//   yumi_i         : dequeue the head (only when v_o is 1)
module bsg_two_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_r [2];
    logic               head_r;
    logic               tail_r;
    logic [1:0]         count_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_r  <= 1'b0;
            tail_r  <= 1'b0;
            count_r <= 2'd0;
        end else begin
            if (v_i)    tail_r <= ~tail_r;
            if (yumi_i) head_r <= ~head_r;
            count_r <= count_r + {1'b0, v_i} - {1'b0, yumi_i};
        end
    end

    // Storage needs no reset: the head is only consumed when v_o is 1.
    always_ff @(posedge clk_i) begin
        if (v_i) mem_r[tail_r] <= data_i;
    end

    assign ready_o = (count_r != 2'd2);
    assign v_o     = (count_r != 2'd0);
    assign data_o  = mem_r[head_r];

endmodule

// File: rtl/bsg_link_oddr_upstream_sender.sv
// Upstream sender for the ODDR link PHY. Buffers a valid/ready channel in a
// two-entry FIFO, applies credit flow control against the receiver buffer,
// sends an idle sync preamble after reset, then packs one channel word plus
// a valid flag into each half of the 2*phy_width_p PHY word.
//   clk_i, reset_i : core/PHY clock, synchronous active-high reset
//   v_i, data_i    : channel input; ready_o accepts
//   token_i        : one-cycle credit-return pulse (clk_i domain)
//   phy_ready_i    : PHY samples phy_data_o at posedges where this is 1
//   phy_data_o     : packed PHY word
//   sync_done_o    : high once live traffic is allowed
module bsg_link_oddr_upstream_sender
    import bsg_link_pkg::*;
#(
    parameter int phy_width_p                     = 16,
    parameter int width_p                         = 2*phy_width_p-2,
    parameter int lg_fifo_depth_p                 = 3,
    parameter int lg_credit_to_token_decimation_p = 0,
    parameter int sync_transfers_p                = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic [width_p-1:0]       data_i,
    output logic                     ready_o,
    input  logic                     token_i,
    input  logic                     phy_ready_i,
    output logic [2*phy_width_p-1:0] phy_data_o,
    output logic                     sync_done_o
);

    localparam int cw_lp     = credit_width(lg_fifo_depth_p);
    localparam int h_lp      = width_p / 2;
    localparam int pw_lp     = 2 * phy_width_p;
    localparam int sync_w_lp = $clog2(sync_transfers_p + 1);

    localparam logic [cw_lp-1:0]     credit_init_lp = cw_lp'(1 << lg_fifo_depth_p);
    localparam logic [cw_lp-1:0]     token_inc_lp   = cw_lp'(1 << lg_credit_to_token_decimation_p);
    localparam logic [sync_w_lp-1:0] sync_last_lp   = sync_w_lp'(sync_transfers_p - 1);

    link_state_e          state_r, state_n;
    logic [sync_w_lp-1:0] sync_cnt_r;
    logic [cw_lp-1:0]     credit_r, credit_n;

    logic               fifo_ready, fifo_v, fifo_clear, enq, send;
    logic [width_p-1:0] fifo_data;

    // The FIFO is held empty for the whole RESET state, not just while
    // reset_i is high, so nothing stale survives into SYNC.
    assign fifo_clear = reset_i | (state_r == RESET);
    assign enq        = v_i & ready_o;
    assign send       = (state_r == RUN) & phy_ready_i & fifo_v & (credit_r != '0);

    bsg_two_fifo #(.width_p(width_p)) fifo (
        .clk_i   (clk_i),
        .reset_i (fifo_clear),
        .ready_o (fifo_ready),
        .data_i  (data_i),
        .v_i     (enq),
        .v_o     (fifo_v),
        .data_o  (fifo_data),
        .yumi_i  (send)
    );

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= RESET;
        else         state_r <= state_n;
    end

    // FSM: next state
    always_comb begin
        state_n = state_r;
        case (state_r)
            RESET:   state_n = SYNC;
            SYNC:    if (phy_ready_i && (sync_cnt_r == sync_last_lp)) state_n = RUN;
            RUN:     state_n = RUN;
            default: state_n = RESET;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready_o     = 1'b0;
        sync_done_o = 1'b0;
        if (state_r != RESET) ready_o = fifo_ready;
        if (state_r == RUN)   sync_done_o = 1'b1;
    end

    // Counts idle transfers the PHY actually took during SYNC.
    always_ff @(posedge clk_i) begin
        if (reset_i || state_r == RESET)       sync_cnt_r <= '0;
        else if (state_r == SYNC && phy_ready_i) sync_cnt_r <= sync_cnt_r + 1'b1;
    end

    // Send and token in the same cycle both apply; tokens during RESET are
    // dropped because the counter is being reloaded.
    assign credit_n = credit_r - cw_lp'(send) + (token_i ? token_inc_lp : '0);

    always_ff @(posedge clk_i) begin
        if (reset_i || state_r == RESET) begin
            credit_r <= credit_init_lp;
        end else begin
            credit_r <= credit_n;
            assert (int'(credit_r) - int'(send) + (token_i ? int'(token_inc_lp) : 0)
                    <= int'(credit_init_lp))
                else $error("credit counter overflow");
        end
    end

    // Each PHY half carries the send flag on top of half the channel word;
    // the whole word is forced to idle when nothing is sent.
    assign phy_data_o = send ? {1'b1, fifo_data[width_p-1:h_lp], 1'b1, fifo_data[h_lp-1:0]}
                             : pw_lp'(idle_word_lp);

endmodule

// File: tb/tb_bsg_link_oddr_upstream_sender.sv
// Directed bench for bsg_link_oddr_upstream_sender (phy_width_p=16).
module tb_bsg_link_oddr_upstream_sender;

    localparam int W = 30;

    logic         clk = 1'b0;
    logic         reset_i, v_i, token_i, phy_ready_i;
    logic [W-1:0] data_i;
    logic         ready_o, sync_done_o;
    logic [31:0]  phy_data_o;

    int checks = 0;
    int failures = 0;
    int idx = 0;
    int sends = 0;
    bit stream_en = 1'b0;

    always #5 clk = ~clk;

    bsg_link_oddr_upstream_sender dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .v_i         (v_i),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .token_i     (token_i),
        .phy_ready_i (phy_ready_i),
        .phy_data_o  (phy_data_o),
        .sync_done_o (sync_done_o)
    );

    function automatic logic [31:0] pack(input logic [W-1:0] w);
        return {1'b1, w[29:15], 1'b1, w[14:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock of streaming: offers word 0x100+idx while idx<12, checks any
    // send against the next word in order, then advances past the edge.
    task automatic cycle();
        if (stream_en) begin
            v_i    = (idx < 12);
            data_i = W'(32'h100 + idx);
        end
        #1;
        if (phy_data_o[15] || phy_data_o[31]) begin
            checks++;
            if (phy_data_o !== pack(W'(32'h100 + sends))) begin
                failures++;
                $display("FAIL send_data got=%h exp=%h", phy_data_o, pack(W'(32'h100 + sends)));
            end
            sends++;
        end
        if (stream_en && v_i && ready_o) idx++;
        step();
    endtask

    task automatic test_reset();
        reset_i = 1'b1; v_i = 1'b1; token_i = 1'b0; phy_ready_i = 1'b1; data_i = '0;
        repeat (3) step();
        #1;
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        checks++; if (sync_done_o !== 1'b0) begin failures++; $display("FAIL reset_sync_done got=%b exp=0", sync_done_o); end
        checks++; if (phy_data_o !== 32'h0) begin failures++; $display("FAIL reset_phy_data got=%h exp=0", phy_data_o); end
        checks++; if (dut.credit_r !== 4'd8) begin failures++; $display("FAIL reset_credit got=%0d exp=8", dut.credit_r); end
        v_i = 1'b0; phy_ready_i = 1'b0;
    endtask

    task automatic test_sync();
        reset_i = 1'b0;
        step();
        for (int i = 0; i < 7; i++) begin
            phy_ready_i = (i % 2 == 0);
            #1;
            checks++; if (sync_done_o !== 1'b0) begin failures++; $display("FAIL sync_early i=%0d got=%b exp=0", i, sync_done_o); end
            checks++; if (phy_data_o !== 32'h0) begin failures++; $display("FAIL sync_idle i=%0d got=%h exp=0", i, phy_data_o); end
            step();
        end
        phy_ready_i = 1'b0;
        #1;
        checks++; if (sync_done_o !== 1'b1) begin failures++; $display("FAIL sync_done got=%b exp=1", sync_done_o); end
    endtask

    task automatic test_single_word();
        phy_ready_i = 1'b0; v_i = 1'b1; data_i = 30'h2AAA_5555;
        #1;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", ready_o); end
        step();
        v_i = 1'b0; phy_ready_i = 1'b1;
        #1;
        checks++; if (phy_data_o !== 32'hD554_D555) begin failures++; $display("FAIL single_pack got=%h exp=D554D555", phy_data_o); end
        step();
        checks++; if (dut.credit_r !== 4'd7) begin failures++; $display("FAIL single_credit got=%0d exp=7", dut.credit_r); end
        checks++; if (phy_data_o !== 32'h0) begin failures++; $display("FAIL single_empty got=%h exp=0", phy_data_o); end
        phy_ready_i = 1'b0; token_i = 1'b1;
        step();
        token_i = 1'b0;
        checks++; if (dut.credit_r !== 4'd8) begin failures++; $display("FAIL token_restore got=%0d exp=8", dut.credit_r); end
    endtask

    task automatic test_credit_exhaust();
        stream_en = 1'b1; idx = 0; sends = 0; phy_ready_i = 1'b1;
        repeat (30) cycle();
        checks++; if (sends !== 8) begin failures++; $display("FAIL exhaust_sends got=%0d exp=8", sends); end
        checks++; if (idx !== 10) begin failures++; $display("FAIL exhaust_accepted got=%0d exp=10", idx); end
        checks++; if (dut.credit_r !== 4'd0) begin failures++; $display("FAIL exhaust_credit got=%0d exp=0", dut.credit_r); end
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL exhaust_ready got=%b exp=0", ready_o); end
        checks++; if (phy_data_o !== 32'h0) begin failures++; $display("FAIL exhaust_idle got=%h exp=0", phy_data_o); end
        token_i = 1'b1;
        cycle();
        token_i = 1'b0;
        repeat (5) cycle();
        checks++; if (sends !== 9) begin failures++; $display("FAIL token_one_send got=%0d exp=9", sends); end
        checks++; if (idx !== 11) begin failures++; $display("FAIL token_accepted got=%0d exp=11", idx); end
    endtask

    task automatic test_backpressure();
        phy_ready_i = 1'b0; token_i = 1'b1;
        cycle();
        token_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready i=%0d got=%b exp=0", i, ready_o); end
            checks++; if (dut.credit_r !== 4'd1) begin failures++; $display("FAIL bp_credit i=%0d got=%0d exp=1", i, dut.credit_r); end
            checks++; if (dut.fifo_data !== 30'h109) begin failures++; $display("FAIL bp_head i=%0d got=%h exp=109", i, dut.fifo_data); end
        end
        phy_ready_i = 1'b1;
        cycle();
        checks++; if (sends !== 10) begin failures++; $display("FAIL bp_resume got=%0d exp=10", sends); end
        phy_ready_i = 1'b0;
        repeat (2) cycle();
        checks++; if (idx !== 12) begin failures++; $display("FAIL bp_accepted got=%0d exp=12", idx); end
    endtask

    task automatic test_back_to_back_token();
        phy_ready_i = 1'b0; token_i = 1'b1;
        repeat (3) cycle();
        token_i = 1'b0;
        checks++; if (dut.credit_r !== 4'd3) begin failures++; $display("FAIL simul_pre got=%0d exp=3", dut.credit_r); end
        phy_ready_i = 1'b1; token_i = 1'b1;
        cycle();
        token_i = 1'b0;
        checks++; if (dut.credit_r !== 4'd3) begin failures++; $display("FAIL simul_credit got=%0d exp=3", dut.credit_r); end
        checks++; if (sends !== 11) begin failures++; $display("FAIL simul_sends got=%0d exp=11", sends); end
        cycle();
        checks++; if (dut.credit_r !== 4'd2) begin failures++; $display("FAIL drain_credit got=%0d exp=2", dut.credit_r); end
        checks++; if (sends !== 12) begin failures++; $display("FAIL drain_sends got=%0d exp=12", sends); end
        stream_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        phy_ready_i = 1'b0; v_i = 1'b1; data_i = 30'h3AB;
        step();
        data_i = 30'h3AC;
        step();
        v_i = 1'b0;
        checks++; if (dut.fifo_v !== 1'b1) begin failures++; $display("FAIL mid_fifo_loaded got=%b exp=1", dut.fifo_v); end
        checks++; if (dut.credit_r !== 4'd2) begin failures++; $display("FAIL mid_credit_pre got=%0d exp=2", dut.credit_r); end
        reset_i = 1'b1; token_i = 1'b1;
        step();
        checks++; if (dut.credit_r !== 4'd8) begin failures++; $display("FAIL mid_credit got=%0d exp=8", dut.credit_r); end
        checks++; if (dut.fifo_v !== 1'b0) begin failures++; $display("FAIL mid_fifo_empty got=%b exp=0", dut.fifo_v); end
        checks++; if (sync_done_o !== 1'b0) begin failures++; $display("FAIL mid_sync_done got=%b exp=0", sync_done_o); end
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL mid_ready got=%b exp=0", ready_o); end
        reset_i = 1'b0;
        step();
        token_i = 1'b0;
        checks++; if (dut.credit_r !== 4'd8) begin failures++; $display("FAIL mid_token_ignored got=%0d exp=8", dut.credit_r); end
        phy_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (sync_done_o !== 1'b0) begin failures++; $display("FAIL resync_early i=%0d got=%b exp=0", i, sync_done_o); end
            checks++; if (phy_data_o !== 32'h0) begin failures++; $display("FAIL resync_idle i=%0d got=%h exp=0", i, phy_data_o); end
            step();
        end
        #1;
        checks++; if (sync_done_o !== 1'b1) begin failures++; $display("FAIL resync_done got=%b exp=1", sync_done_o); end
        checks++; if (phy_data_o !== 32'h0) begin failures++; $display("FAIL resync_discard got=%h exp=0", phy_data_o); end
    endtask

    initial begin
        test_reset();
        test_sync();
        test_single_word();
        test_credit_exhaust();
        test_backpressure();
        test_back_to_back_token();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
